// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder bridging a byte-wide SRAM: 0x03 read / 0x02 write, 16-bit address, unlimited bursts.
// SCLK is oversampled on clk; all SPI inputs are synchronized before use.
module spi_sram_responder #(
  parameter int unsigned CLK_DIV_MIN = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        busy_o
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

  // Minimum SCLK phase length is a timing assumption only; no logic depends on it.
  logic unused_clk_div_c;
  assign unused_clk_div_c = ^32'(CLK_DIV_MIN);

  logic [1:0]        cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic              cs_prev_q, sclk_prev_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] shift_q, shift_d;
  logic              is_read_q, is_read_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;

  logic              cs_s, sclk_s, mosi_s;
  logic              cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [ADDR_W-1:0] shift_in;

  assign cs_s      = cs_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign shift_in  = {shift_q[ADDR_W-2:0], mosi_s};

  // CS sync flops reset low so a CS already asserted at release is not seen as a new falling edge.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      is_read_q   <= 1'b0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n_i};
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      is_read_q   <= is_read_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    is_read_d = is_read_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    // Read data is valid the clk after the strobe; capture it one clk after that.
    load_d    = re_q;

    if (load_q) begin
      tx_d = mem_rdata_i;
    end
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (cs_rise) begin
      // CS release beats any same-clk SCLK edge and drops partial bytes and prefetches.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      tx_d      = '0;
      miso_d    = 1'b0;
      load_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            shift_d   = '0;
            tx_d      = '0;
            miso_d    = 1'b0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (shift_in[DATA_W-1:0] == CMD_READ) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b1;
              end else if (shift_in[DATA_W-1:0] == CMD_WRITE) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b0;
              end else begin
                state_d   = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(15)) begin
              bit_cnt_d = '0;
              addr_d    = shift_in;
              if (is_read_q) begin
                re_d    = 1'b1;
                state_d = ST_READ;
              end else begin
                state_d = ST_WRITE;
              end
            end
          end
        end
        ST_READ: begin
          if (sclk_fall) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          // Prefetch on the edge sampling bit 0 so the next byte is loaded before the next fall.
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + ADDR_W'(1);
              re_d      = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              wdata_d   = shift_in[DATA_W-1:0];
              we_d      = 1'b1;
            end
          end
        end
        ST_IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign spi_miso_o  = miso_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;
  assign mem_re_o    = re_q;
  assign busy_o      = busy_q;

endmodule
